// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, address width and ACK/NACK line levels.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX       = 3'd3,
    RX_ACK   = 3'd4,
    TX       = 3'd5,
    TX_ACK   = 3'd6
  } i2cState;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clock domain and derives bus edges plus START/STOP conditions.
module i2c_bus_sync (
  input  logic clock,
  input  logic Reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [1:0] pins;
  logic [1:0] lineS;
  logic [1:0] linePrev;

  assign pins = {sda, scl};

  // Bit 0 is SCL, bit 1 is SDA; both idle high so reset loads ones.
  for (genvar gi = 0; gi < 2; gi++) begin : gLine
    logic [1:0] syncReg;
    logic       prevReg;

    always_ff @(posedge clock) begin
      if (Reset) begin
        syncReg <= 2'b11;
        prevReg <= 1'b1;
      end else begin
        syncReg <= {syncReg[0], pins[gi]};
        prevReg <= syncReg[1];
      end
    end

    assign lineS[gi]    = syncReg[1];
    assign linePrev[gi] = prevReg;
  end

  assign scl_rise = lineS[0] & ~linePrev[0];
  assign scl_fall = ~lineS[0] & linePrev[0];
  assign start    = lineS[0] & linePrev[0] & linePrev[1] & ~lineS[1];
  assign stop     = lineS[0] & linePrev[0] & ~linePrev[1] & lineS[1];
  assign sda_s    = lineS[1];

endmodule

// File: rtl/i2c_target_unit.sv
// I2C target data unit: address match, write reception with ACK, read transmission
// with controller ACK/NACK sampling, open-drain SDA.
module i2c_target_unit
  import i2c_pkg::*;
#(
  parameter int                LENGTH  = 8,
  parameter logic [ADDR_W-1:0] ADDRESS = 7'h3C
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              SCL,
  inout  wire               SDA,
  input  logic [LENGTH-1:0] TxData,
  output logic              TxRequest,
  output logic [LENGTH-1:0] RxData,
  output logic              RxValid,
  output logic              Busy
);

  localparam logic [3:0] LAST_RX = 4'(LENGTH - 1);
  localparam logic [3:0] LAST_TX = 4'(LENGTH);

  logic              sclRise, sclFall, startSeen, stopSeen, sdaS;
  i2cState           state;
  logic [LENGTH-1:0] shifter;
  logic [LENGTH-1:0] rxByte;
  logic [3:0]        bitCount;
  logic              ackDrive, ackPhase, readMode;

  i2c_bus_sync busSync (
    .clock    (clock),
    .Reset    (Reset),
    .scl      (SCL),
    .sda      (SDA),
    .scl_rise (sclRise),
    .scl_fall (sclFall),
    .start    (startSeen),
    .stop     (stopSeen),
    .sda_s    (sdaS)
  );

  assign rxByte = {shifter[LENGTH-2:0], sdaS};
  assign Busy   = (state != IDLE);

  // Data bits come straight from the shifter MSB while in TX; ACK slots use ackDrive.
  assign SDA = (ackDrive || (state == TX && !shifter[LENGTH-1])) ? 1'b0 : 1'bz;

  always_ff @(posedge clock) begin
    if (Reset) begin
      state     <= IDLE;
      shifter   <= '0;
      bitCount  <= '0;
      ackDrive  <= 1'b0;
      ackPhase  <= 1'b0;
      readMode  <= 1'b0;
      RxData    <= '0;
      RxValid   <= 1'b0;
      TxRequest <= 1'b0;
    end else begin
      RxValid   <= 1'b0;
      TxRequest <= 1'b0;
      if (stopSeen) begin
        state    <= IDLE;
        ackDrive <= 1'b0;
        ackPhase <= 1'b0;
        bitCount <= '0;
      end else if (startSeen) begin
        state    <= ADDR;
        ackDrive <= 1'b0;
        ackPhase <= 1'b0;
        bitCount <= '0;
      end else begin
        case (state)
          ADDR: if (sclRise) begin
            shifter  <= rxByte;
            bitCount <= bitCount + 4'd1;
            if (bitCount == LAST_RX) begin
              bitCount <= '0;
              if (rxByte[LENGTH-1:1] == ADDRESS) begin
                state    <= ADDR_ACK;
                readMode <= rxByte[0];
              end else begin
                state <= IDLE;
              end
            end
          end
          // First falling edge pulls SDA low, the second releases it and moves on.
          ADDR_ACK, RX_ACK: if (sclFall) begin
            ackPhase <= !ackPhase;
            ackDrive <= !ackPhase;
            if (ackPhase) begin
              if (state == ADDR_ACK && readMode) begin
                state     <= TX;
                shifter   <= TxData;
                TxRequest <= 1'b1;
                bitCount  <= 4'd1;
              end else begin
                state <= RX;
              end
            end
          end
          RX: if (sclRise) begin
            shifter <= rxByte;
            if (bitCount == LAST_RX) begin
              bitCount <= '0;
              RxData   <= rxByte;
              RxValid  <= 1'b1;
              state    <= RX_ACK;
            end else begin
              bitCount <= bitCount + 4'd1;
            end
          end
          TX: if (sclFall) begin
            if (bitCount == LAST_TX) begin
              bitCount <= '0;
              state    <= TX_ACK;
            end else begin
              shifter  <= {shifter[LENGTH-2:0], 1'b0};
              bitCount <= bitCount + 4'd1;
            end
          end
          TX_ACK: begin
            if (sclRise) begin
              if (sdaS == ACK) ackPhase <= 1'b1;
              else             state    <= IDLE;
            end else if (sclFall && ackPhase) begin
              ackPhase  <= 1'b0;
              state     <= TX;
              shifter   <= TxData;
              TxRequest <= 1'b1;
              bitCount  <= 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_unit.sv
// Bench for i2c_target_unit: controller model with 16-clock SCL, scoreboard for RxValid/TxRequest.
module tb_i2c_target_unit;
  import i2c_pkg::*;

  localparam logic [6:0] TARGET_ADDR = 7'h3C;

  logic       clock   = 1'b0;
  logic       Reset   = 1'b1;
  logic       scl     = 1'b1;
  logic       ctrlLow = 1'b0;
  logic [7:0] TxData;
  logic       TxRequest, RxValid, Busy;
  logic [7:0] RxData;
  wire        sda;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] rxQ[$];
  logic [7:0] txPlan[$];
  logic [7:0] lastRx = 8'h00;

  assign sda = ctrlLow ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clock = ~clock;

  i2c_target_unit #(.LENGTH(8), .ADDRESS(TARGET_ADDR)) dut (
    .clock     (clock),
    .Reset     (Reset),
    .SCL       (scl),
    .SDA       (sda),
    .TxData    (TxData),
    .TxRequest (TxRequest),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .Busy      (Busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected write bytes on RxValid and planned read bytes on TxRequest.
  always @(negedge clock) begin
    if (RxValid === 1'b1) begin
      if (rxQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_unexpected: got RxValid with RxData %02h, required no pulse", RxData);
      end else begin
        check("rx_data", 32'(RxData), 32'(rxQ.pop_front()));
      end
    end
    if (TxRequest === 1'b1) begin
      tests++;
      if (txPlan.size() == 0) begin
        fails++;
        $display("FAIL tx_request_unexpected: got extra TxRequest, required none");
      end else begin
        void'(txPlan.pop_front());
      end
    end
    TxData = (txPlan.size() != 0) ? txPlan[0] : 8'h00;
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One SCL period: 8 clocks low (data set mid-low), 8 high (sampled mid-high).
  task automatic sendBit(input logic b, output logic seen);
    ctrlLow = ~b;
    waitClk(4);
    scl = 1'b1;
    waitClk(4);
    seen = sda;
    waitClk(4);
    scl = 1'b0;
    waitClk(4);
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) sendBit(b[i], dummy);
    sendBit(1'b1, ack);
  endtask

  task automatic readByte(output logic [7:0] d, input logic ackBit);
    logic b, dummy;
    for (int i = 7; i >= 0; i--) begin
      sendBit(1'b1, b);
      d[i] = b;
    end
    sendBit(ackBit, dummy);
  endtask

  task automatic startCond();
    ctrlLow = 1'b0;
    waitClk(4);
    scl = 1'b1;
    waitClk(4);
    ctrlLow = 1'b1;
    waitClk(4);
    scl = 1'b0;
    waitClk(4);
  endtask

  task automatic stopCond();
    ctrlLow = 1'b1;
    waitClk(4);
    scl = 1'b1;
    waitClk(4);
    ctrlLow = 1'b0;
    waitClk(8);
  endtask

  task automatic writeXfer(input logic [7:0] addrByte, input logic [7:0] bytes[$]);
    logic ack, match;
    match = (addrByte[7:1] == TARGET_ADDR) && (addrByte[0] == 1'b0);
    startCond();
    sendByte(addrByte, ack);
    check("write_addr_ack", 32'(ack), 32'(match ? ACK : NACK));
    check("busy_after_addr", 32'(Busy), 32'(match));
    foreach (bytes[i]) begin
      if (match) begin
        rxQ.push_back(bytes[i]);
        lastRx = bytes[i];
      end
      sendByte(bytes[i], ack);
      check("write_data_ack", 32'(ack), 32'(match ? ACK : NACK));
    end
    stopCond();
    check("busy_after_stop", 32'(Busy), 32'(0));
  endtask

  // Controller ACKs every byte except the last, which it NACKs.
  task automatic readXfer(input logic [7:0] bytes[$]);
    logic ack;
    logic [7:0] got;
    foreach (bytes[i]) txPlan.push_back(bytes[i]);
    startCond();
    sendByte({TARGET_ADDR, 1'b1}, ack);
    check("read_addr_ack", 32'(ack), 32'(ACK));
    for (int i = 0; i < bytes.size(); i++) begin
      readByte(got, (i == bytes.size() - 1) ? NACK : ACK);
      check("read_data", 32'(got), 32'(bytes[i]));
    end
    check("busy_after_nack", 32'(Busy), 32'(0));
    stopCond();
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] d;
    logic       ack, b;

    waitClk(3);
    check("reset_busy", 32'(Busy), 32'(0));
    check("reset_rxvalid", 32'(RxValid), 32'(0));
    check("reset_txrequest", 32'(TxRequest), 32'(0));
    check("reset_rxdata", 32'(RxData), 32'(0));
    check("reset_sda", 32'(sda), 32'(1));
    Reset = 1'b0;
    waitClk(4);

    q = {8'hA5, 8'h5A};
    writeXfer(8'h78, q);
    q = {8'hA5};
    writeXfer(8'h7A, q);
    q = {8'h11};
    writeXfer(8'h00, q);
    q = {8'hC3, 8'h3C};
    readXfer(q);

    // Repeated start after four data bits of a write.
    startCond();
    sendByte(8'h78, ack);
    check("rs_addr_ack", 32'(ack), 32'(ACK));
    for (int i = 0; i < 4; i++) sendBit(1'($urandom_range(0, 1)), b);
    q = {8'h96, 8'h0F};
    readXfer(q);

    // Reset pulse while the data ACK is being driven.
    startCond();
    sendByte(8'h78, ack);
    check("rst_addr_ack", 32'(ack), 32'(ACK));
    d = 8'($urandom);
    rxQ.push_back(d);
    for (int i = 7; i >= 0; i--) sendBit(d[i], b);
    ctrlLow = 1'b0;
    waitClk(1);
    check("ack_driven", 32'(sda), 32'(0));
    Reset = 1'b1;
    waitClk(1);
    check("rst_sda_released", 32'(sda), 32'(1));
    check("rst_busy", 32'(Busy), 32'(0));
    check("rst_rxdata", 32'(RxData), 32'(0));
    check("rst_rxvalid", 32'(RxValid), 32'(0));
    check("rst_txrequest", 32'(TxRequest), 32'(0));
    Reset = 1'b0;
    lastRx = 8'h00;
    stopCond();
    q = {8'($urandom)};
    writeXfer(8'h78, q);

    // Stop after three data bits.
    startCond();
    sendByte(8'h78, ack);
    check("es_addr_ack", 32'(ack), 32'(ACK));
    for (int i = 0; i < 3; i++) sendBit(1'($urandom_range(0, 1)), b);
    stopCond();
    check("es_busy", 32'(Busy), 32'(0));
    check("es_rxdata_held", 32'(RxData), 32'(lastRx));

    for (int t = 0; t < 6; t++) begin
      int         kind, n;
      logic [6:0] a;
      kind = int'($urandom_range(0, 2));
      n    = int'($urandom_range(1, 3));
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      case (kind)
        0: writeXfer({TARGET_ADDR, 1'b0}, q);
        1: begin
          a = 7'($urandom);
          if (a == TARGET_ADDR) a = a ^ 7'h01;
          writeXfer({a, 1'b0}, q);
        end
        default: readXfer(q);
      endcase
    end

    waitClk(10);
    check("rx_queue_drained", 32'(rxQ.size()), 32'(0));
    check("tx_plan_drained", 32'(txPlan.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_target_unit.md
# i2c_target_unit

I2C target-side (slave) data unit: responds on the open-drain SDA line to an I2C controller that drives SCL. It detects START/STOP, matches a 7-bit address, receives write bytes with ACK, and transmits read bytes while sampling the controller's ACK/NACK. It is the counterpart of the team's controller-side data unit and is used to exercise that unit and to attach on-chip register targets.

## Interface
- LENGTH, 8, data byte width; only 8 is supported.
- ADDRESS, 7'h3C, 7-bit target address matched against the address byte.
- clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- SCL  input  1  bus clock from the controller; this block never stretches it.
- SDA  inout  1  open-drain data line; driven only to 0, otherwise high-Z.
- TxData  input  LENGTH  byte to send on a read; sampled in the TxRequest cycle.
- TxRequest  output  1  one-cycle pulse when TxData is latched into the shifter.
- RxData  output  LENGTH  last received write-data byte; held until the next byte.
- RxValid  output  1  one-cycle pulse when RxData updates.
- Busy  output  1  high whenever state is not IDLE.

## Operation
- SCL and SDA each pass through a 2-FF synchronizer plus an edge register. Derived events: scl_rise, scl_fall, start (SDA falls while SCL is high), stop (SDA rises while SCL is high).
- Priority within a cycle: stop > start > SCL edges.
- A start in any state (repeated start included) goes to ADDR: bit count 0, SDA released.
- A stop in any state goes to IDLE with SDA released.
- States:
  - IDLE: wait for start.
  - ADDR: shift SDA in MSB-first on each scl_rise. After bit 8, if byte[7:1]==ADDRESS, latch RW=byte[0] and go to ADDR_ACK; otherwise go to IDLE, SDA untouched.
  - ADDR_ACK: at the next scl_fall, drive SDA=0; at the following scl_fall, release. If RW=1, go to TX and load; if RW=0, go to RX.
  - RX: shift 8 bits on scl_rise. On the 8th, update RxData, pulse RxValid, go to RX_ACK.
  - RX_ACK: drive 0 at the next scl_fall, release at the following scl_fall, then return to RX.
  - TX load: load the shifter from TxData and pulse TxRequest in the same cycle. Drive the MSB immediately (0 → drive low, 1 → release). Each later scl_fall shifts out the next bit.
  - TX: the scl_fall after bit 8 releases SDA and goes to TX_ACK.
  - TX_ACK: sample SDA at scl_rise. ACK (0) → at the next scl_fall, load and continue TX. NACK (1) → IDLE.
- General-call address 0x00 is not special; it is NACKed unless ADDRESS is 0.

## Timing
- Reset values:
  - state IDLE, SDA high-Z.
  - RxData 0, RxValid 0, TxRequest 0, Busy 0.
  - shifter 0, bit count 0.
  - synchronizer flops 1 (bus idle high).
- Reset during any state, including while driving ACK: SDA is high-Z from the first clock edge with Reset high.
- Latency: an SCL or SDA pin edge is acted on 3 clocks later (2 synchronizer stages + 1 edge register).
  - An SDA change caused by scl_fall appears 3 clocks after the SCL pin falls.
  - RxValid is asserted 3 clocks after the 8th SCL pin rise.
- Bus requirements:
  - SCL high and low phases ≥ 6 clocks each.
  - Controller SDA changes ≥ 4 clocks away from SCL edges.
  - Violating these is unsupported.
- A start or stop mid-byte discards the partial byte: no RxValid, no TxRequest.
- Bit count wraps 8 → 0 at each ACK phase; there is no limit on bytes per transfer.

## Structure
- Package i2c_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK).
  - ADDR_W=7.
  - ACK=1'b0 and NACK=1'b1 constants.
- Sub-module i2c_bus_sync:
  - Synchronizers and edge detection.
  - Outputs scl_rise, scl_fall, start, stop, sda_s.
  - Shared with the controller-side unit for bus monitoring.
- Top level: FSM, 8-bit shifter, 4-bit bit counter, open-drain driver (SDA = drive_low ? 1'b0 : 1'bz).

## Test plan
All scenarios use ADDRESS=7'h3C, a controller model with SCL period 16 clocks, and a pullup on SDA.
- Write: address byte 0x78, then 0xA5, 0x5A, then stop → SDA low on all three 9th clocks; RxValid pulses twice with RxData 0xA5 then 0x5A; Busy falls after the stop.
- Mismatch: address 0x7A, then 0xA5 → SDA never driven low; no RxValid; Busy 0 after address bit 8.
- Read: address 0x79 with TxData 0xC3, changed to 0x3C after the first TxRequest; controller ACKs byte 1 and NACKs byte 2 → SDA carries 11000011 then 00111100; exactly two TxRequest pulses; IDLE after the NACK.
- Repeated start after 4 data bits of a write, then 0x79 → partial byte dropped (no RxValid); address ACK driven; read proceeds.
- Reset: Reset pulsed for 1 clock while driving ACK low → SDA high-Z on the next clock; all outputs at reset values; the next START/0x78 is ACKed normally.
- Early stop: stop after 3 data bits → state IDLE; RxValid never pulses; RxData keeps its previous value.
